// File: rtl/mem_arb_pkg.sv
// Shared types for the data memory arbiter.
//   NUM_PORTS   : number of requesters sharing the memory
//   port_idx_t  : index of a requester
//   arb_state_t : sequencing FSM states
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner selection, purely combinational.
//   req  : request vector, bit i for port i
//   last : port served by the most recent grant
//   win  : one-hot winner (zero when nobody requests)
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last,
    output logic [NUM_PORTS-1:0] win
);

    always_comb begin
        win = '0;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // Contention: the port that was not served last goes next.
            2'b11:   win = (last == port_idx_t'(0)) ? 2'b10 : 2'b01;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the CPU load/store path (port 0)
// and the debug/program loader (port 1). One transaction at a time: grant in
// IDLE, one memory strobe in ACCESS, READ_LATENCY cycles in WAIT for reads,
// one-cycle completion pulse in RESP.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/addr/wdata     requester N command, held until gnt[N]
//   gnt, done                one-hot accept / completion pulses
//   rdata, err               response, valid while done is nonzero
//   mem_*                    memory side; strobes last exactly one cycle
//
// Build option: MEM_ARB_RANGE_CHECK_EN. When defined, addresses >= DEPTH
// complete with err=1 and never strobe the memory. Otherwise addresses wrap
// modulo DEPTH and err is always 0.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [31:0]          p0_addr,
    input  logic [31:0]          p0_wdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [31:0]          p1_addr,
    input  logic [31:0]          p1_wdata,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [NUM_PORTS-1:0] done,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [31:0]          mem_rdata
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

    arb_state_t     state_q, state_d;
    port_idx_t      last_q, last_d;
    port_idx_t      owner_q, owner_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] win;
    port_idx_t            win_idx;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic                 range_err;
    logic [31:0]          access_addr;

    rr_arbiter2 u_rr (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .win  (win)
    );

    assign win_idx   = port_idx_t'(win[1]);
    assign sel_we    = win[1] ? p1_we    : p0_we;
    assign sel_addr  = win[1] ? p1_addr  : p0_addr;
    assign sel_wdata = win[1] ? p1_wdata : p0_wdata;

`ifdef MEM_ARB_RANGE_CHECK_EN
    logic oor_q, oor_d;

    assign range_err   = oor_q;
    assign access_addr = addr_q;
`else
    logic unused_addr_hi;

    assign range_err      = 1'b0;
    assign access_addr    = 32'(addr_q[AW-1:0]);
    assign unused_addr_hi = ^addr_q[31:AW];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= port_idx_t'(1);  // port 0 wins the first contention
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef MEM_ARB_RANGE_CHECK_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef MEM_ARB_RANGE_CHECK_EN
            oor_q   <= oor_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef MEM_ARB_RANGE_CHECK_EN
        oor_d   = oor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|win) begin
                    state_d = StAccess;
                    last_d  = win_idx;
                    owner_d = win_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rdata_d = '0;  // writes and rejected accesses return 0
`ifdef MEM_ARB_RANGE_CHECK_EN
                    oor_d   = (sel_addr >= 32'(DEPTH));
`endif
                end
            end
            StAccess: begin
                if (we_q || range_err) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = CntW'(READ_LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    rdata_d = mem_rdata;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        gnt       = '0;
        done      = '0;
        rdata     = '0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state_q)
            // A grant during reset would be lost, so it is suppressed.
            StIdle: if (!rst) gnt = win;
            StAccess: begin
                mem_addr  = access_addr;
                mem_wdata = wdata_q;
                mem_read  = !we_q && !range_err;
                mem_write = we_q && !range_err;
            end
            StResp: begin
                done[owner_q] = 1'b1;
                rdata         = rdata_q;
                err           = range_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter. Two instances: A with READ_LATENCY=1,
// B with READ_LATENCY=3. Stimulus pushes expected strobes and responses;
// per-instance monitors pop and compare when the DUT strobes or completes.
module tb_data_mem_arbiter;

    localparam int unsigned DEPTH = 256;

    typedef struct {
        int          cyc;
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req [2];
    logic        p0_we [2];
    logic [31:0] p0_addr [2];
    logic [31:0] p0_wdata [2];
    logic        p1_req [2];
    logic        p1_we [2];
    logic [31:0] p1_addr [2];
    logic [31:0] p1_wdata [2];
    logic [1:0]  gnt [2];
    logic [1:0]  done [2];
    logic [31:0] rdata [2];
    logic        err [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [31:0] mem_rdata [2];

    resp_t rq [2][$];
    strb_t sq [2][$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    done_cnt [2] = '{0, 0};
    logic  busy [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .gnt(gnt[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
    );

    data_mem_arbiter #(.DEPTH(DEPTH), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .gnt(gnt[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Memory model and monitor per instance.
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        localparam int L = (gi == 0) ? 1 : 3;
        logic [31:0] mem [DEPTH];
        logic [31:0] pipe [L];

        always @(posedge clk) begin
            if (mem_write[gi]) mem[mem_addr[gi][7:0]] <= mem_wdata[gi];
            pipe[0] <= mem_read[gi] ? mem[mem_addr[gi][7:0]] : 32'hBAAD_F00D;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[gi] = pipe[L-1];

        always begin : mon
            resp_t r;
            strb_t s;
            @(negedge clk);
            #2;
            if (rst) begin
                busy[gi] = 1'b0;
            end else begin
                if (gnt[gi] != 2'b00) begin
                    chk("gnt_only_when_idle", 32'(busy[gi]), 32'd0);
                    busy[gi] = 1'b1;
                end
                if (mem_read[gi] || mem_write[gi]) begin
                    chk("strobe_expected", 32'(sq[gi].size() != 0), 32'd1);
                    if (sq[gi].size() != 0) begin
                        s = sq[gi].pop_front();
                        chk("strobe_cycle", cyc, s.cyc);
                        chk("mem_write", 32'(mem_write[gi]), 32'(s.we));
                        chk("mem_read", 32'(mem_read[gi]), 32'(!s.we));
                        chk("mem_addr", mem_addr[gi], s.addr);
                        if (s.we) chk("mem_wdata", mem_wdata[gi], s.wdata);
                    end
                end
                if (done[gi] != 2'b00) begin
                    done_cnt[gi]++;
                    busy[gi] = 1'b0;
                    chk("done_expected", 32'(rq[gi].size() != 0), 32'd1);
                    if (rq[gi].size() != 0) begin
                        r = rq[gi].pop_front();
                        chk("done_cycle", cyc, r.cyc);
                        chk("done_port", 32'(done[gi]), 32'(r.done));
                        chk("rdata", rdata[gi], r.rdata);
                        chk("err", 32'(err[gi]), 32'(r.err));
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req[d] = req; p0_we[d] = we; p0_addr[d] = addr; p0_wdata[d] = wdata;
        end else begin
            p1_req[d] = req; p1_we[d] = we; p1_addr[d] = addr; p1_wdata[d] = wdata;
        end
    endtask

    // Issue one request, wait for its grant, queue the expected strobe and response.
    task automatic do_req(input int d, input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_maddr,
                          input logic [31:0] exp_rdata, input logic exp_err, output int g);
        int    n;
        resp_t r;
        strb_t s;
        drive(d, p, 1'b1, we, addr, wdata);
        #1;
        n = 0;
        while (gnt[d][p] !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("gnt_value", 32'(gnt[d]), (p == 0) ? 32'd1 : 32'd2);
        g       = cyc;
        r.cyc   = g + 2 + ((we || exp_err) ? 0 : rl_of(d));
        r.done  = (p == 0) ? 2'b01 : 2'b10;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        rq[d].push_back(r);
        if (!exp_err) begin
            s.cyc = g + 1; s.we = we; s.addr = exp_maddr; s.wdata = wdata;
            sq[d].push_back(s);
        end
        @(negedge clk);
        drive(d, p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (rq[d].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(rq[d].size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int g, rc, dc;
        int ord[$];
        int gcy[$];
        int exp_ord [4] = '{0, 1, 0, 1};
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1'b0, 1'b0, 32'd0, 32'd0);
            drive(d, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Reset with p0 requesting: everything quiet, then immediate grant.
        rst = 1'b1;
        drive(0, 0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        chk("rst_mem_wdata", mem_wdata[0], 32'd0);
        chk("rst_mem_read", 32'(mem_read[0]), 32'd0);
        chk("rst_mem_write", 32'(mem_write[0]), 32'd0);
        rst = 1'b0;
        rc  = cyc;
        do_req(0, 0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd5, 32'd0, 1'b0, g);
        chk("first_gnt_cycle", g, rc);
        do_req(0, 0, 1'b0, 32'd5, 32'd0, 32'd5, 32'hDEADBEEF, 1'b0, g);
        chk("regrant_spacing", g - rc, 32'd3);
        wait_idle(0);

        // Out-of-range read: wraps to 44 or is rejected.
        do_req(0, 1, 1'b1, 32'd44, 32'hA5A5_0044, 32'd44, 32'd0, 1'b0, g);
`ifdef MEM_ARB_RANGE_CHECK_EN
        do_req(0, 0, 1'b0, 32'd300, 32'd0, 32'd0, 32'd0, 1'b1, g);
`else
        do_req(0, 0, 1'b0, 32'd300, 32'd0, 32'd44, 32'hA5A5_0044, 1'b0, g);
`endif
        wait_idle(0);

        // Both ports requesting continuously after reset: 0,1,0,1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fork
            begin
                int g0;
                do_req(0, 0, 1'b1, 32'd10, 32'h1010_1010, 32'd10, 32'd0, 1'b0, g0);
                ord.push_back(0); gcy.push_back(g0);
                do_req(0, 0, 1'b1, 32'd11, 32'h1111_1111, 32'd11, 32'd0, 1'b0, g0);
                ord.push_back(0); gcy.push_back(g0);
            end
            begin
                int g1;
                do_req(0, 1, 1'b1, 32'd20, 32'h2020_2020, 32'd20, 32'd0, 1'b0, g1);
                ord.push_back(1); gcy.push_back(g1);
                do_req(0, 1, 1'b1, 32'd21, 32'h2121_2121, 32'd21, 32'd0, 1'b0, g1);
                ord.push_back(1); gcy.push_back(g1);
            end
        join
        chk("grant_count", 32'(ord.size()), 32'd4);
        for (int i = 0; i < 4 && i < ord.size(); i++) chk("grant_order", ord[i], exp_ord[i]);
        for (int i = 1; i < 4 && i < gcy.size(); i++) chk("grant_spacing", gcy[i] - gcy[i-1], 32'd3);
        do_req(0, 1, 1'b0, 32'd21, 32'd0, 32'd21, 32'h2121_2121, 1'b0, g);
        wait_idle(0);

        // READ_LATENCY=3 on instance B.
        do_req(1, 1, 1'b1, 32'd9, 32'h0BAD_CAFE, 32'd9, 32'd0, 1'b0, g);
        do_req(1, 1, 1'b0, 32'd9, 32'd0, 32'd9, 32'h0BAD_CAFE, 1'b0, g);
        wait_idle(1);

        // Reset during WAIT: read abandoned, held p1_req granted right after release.
        do_req(1, 1, 1'b0, 32'd9, 32'd0, 32'd9, 32'h0BAD_CAFE, 1'b0, g);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 1'b1, 1'b0, 32'd9, 32'd0);
        rq[1].delete();
        dc = done_cnt[1];
        @(negedge clk);
        #1;
        chk("gnt_in_reset", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rc  = cyc;
        do_req(1, 1, 1'b0, 32'd9, 32'd0, 32'd9, 32'h0BAD_CAFE, 1'b0, g);
        chk("gnt_after_reset", g, rc);
        wait_idle(1);
        chk("done_count_after_reset", done_cnt[1] - dc, 32'd1);

        wait_idle(0);
        chk("strobe_queue_a", 32'(sq[0].size()), 32'd0);
        chk("strobe_queue_b", 32'(sq[1].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencing controller that shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/program loader). Each port uses a req/gnt/done handshake. The block runs a small FSM that issues one memory strobe per transaction and waits a fixed read latency. It returns read data and completion to the winning port, and sits directly in front of the data memory.

## Interface
- `DEPTH`, 256, memory size in 32-bit words; power of two.
- `READ_LATENCY`, 1, cycles from `mem_read` strobe to valid `mem_rdata`; must be at least 1.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `p0_req`, `p1_req`  in  1  access request; held until `gnt` seen.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; valid with `req`.
- `p0_addr`, `p1_addr`  in  32  word address; valid with `req`.
- `p0_wdata`, `p1_wdata`  in  32  write data; valid with `req`.
- `gnt`  out  2  one-hot request-accepted pulse; bit i for port i.
- `done`  out  2  one-hot completion pulse; bit i for port i.
- `rdata`  out  32  read data; valid only while `done` is nonzero.
- `err`  out  1  access error; valid with `done` (see Configuration).
- `mem_addr`  out  32  address to memory.
- `mem_wdata`  out  32  write data to memory.
- `mem_read`  out  1  one-cycle read strobe.
- `mem_write`  out  1  one-cycle write strobe.
- `mem_rdata`  in  32  memory read data.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any `req` is high, select a winner, assert `gnt[winner]` combinationally in the same cycle, and latch that port's `we`/`addr`/`wdata`.
  - Go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:**
  - Only one requester: it wins.
  - Both requesting: round-robin, the port not served last wins.
  - Pointer after reset favours port 0.
  - Pointer updates on every grant.
- **ACCESS:** drive `mem_addr` and `mem_wdata` from the latch for exactly one cycle.
  - Write: pulse `mem_write`, then go to RESP.
  - Read: pulse `mem_read`, load the latency counter with `READ_LATENCY`, then go to WAIT.
- **WAIT:** decrement the counter each cycle. In the cycle the counter reaches 1, register `mem_rdata` into `rdata` and go to RESP.
- **RESP:** pulse `done[owner]` for one cycle, drive `rdata` (0 for writes) and `err`, then go to IDLE.
- **Busy behaviour:** `gnt` is never asserted outside IDLE. A requester that raises `req` while the block is busy keeps holding it and is considered in the next IDLE cycle.
- **Outputs outside ACCESS:** `mem_read`, `mem_write` = 0; `mem_addr`, `mem_wdata` = 0.
- **Output reset values:** `gnt`=0, `done`=0, `rdata`=0, `err`=0, all `mem_*` = 0. State returns to IDLE and the RR pointer is set to favour port 0.
- **Reset mid-transaction:** the transaction is abandoned with no `done`. A strobe asserted in the reset cycle is dropped from the next cycle onward.

## Timing
- Grant at cycle t (IDLE).
- Write: `mem_write` at t+1, `done` at t+2, next grant possible at t+3.
- Read: `mem_read` at t+1, `mem_rdata` sampled at t+1+`READ_LATENCY`, `done`/`rdata` at t+2+`READ_LATENCY`.
- Peak throughput: one write every 3 cycles; one read every 3+`READ_LATENCY` cycles.
- Back-to-back requests with both ports always requesting: grants alternate 0,1,0,1.

## Configuration
- Macro: `MEM_ARB_RANGE_CHECK_EN`.
- **Defined:** in IDLE, a granted address with `addr >= DEPTH` is flagged.
  - ACCESS asserts no memory strobe.
  - The FSM then goes directly to RESP with `err`=1 and `rdata`=0.
- **Undefined:**
  - Addresses are truncated to `$clog2(DEPTH)` bits, so they wrap modulo `DEPTH`.
  - `err` is tied to 0.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum `arb_state_t` (IDLE, ACCESS, WAIT, RESP)
  - `NUM_PORTS`=2
  - port index typedef `port_idx_t`
- **Sub-module `rr_arbiter2`:**
  - inputs: `req[1:0]`, last-served pointer
  - output: one-hot winner
  - purely combinational
  - pointer register lives in the parent.

## Test plan
- **Reset:** reset with `p0_req`=1 asserted → all outputs 0. First cycle after reset: `gnt`=2'b01.
- **Write then read:** p0 writes 0xDEADBEEF to addr 5, then reads addr 5 with `READ_LATENCY`=1.
  - Write: `mem_write` at t+1, `done`=2'b01 at t+2.
  - Read: `done` at t+3 of the read grant with `rdata`=0xDEADBEEF.
- **Simultaneous requests:** both ports request continuously for 4 transactions → grant order 0,1,0,1, and no `gnt` while busy.
- **Read latency:** `READ_LATENCY`=3, p1 reads → `mem_read` at t+1, `done`=2'b10 at t+5, `rdata` equals the memory value.
- **Range check:** with `MEM_ARB_RANGE_CHECK_EN`, p0 reads addr 300 (`DEPTH`=256) → no `mem_read`, `done` with `err`=1 and `rdata`=0. Without the macro: `mem_addr`=44, `err`=0.
- **Reset mid-read:** assert `rst` during WAIT → no `done`, FSM in IDLE. A held `p1_req` is granted in the first cycle after reset is released.
